// File: rtl/riscky_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package riscky_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    // One buffered fetch: the word and the PC it was read from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries. Flush beats push and pop.
// The caller never pushes into a full FIFO without popping in the same cycle.
module fetch_fifo
    import riscky_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Status and head outputs.
    always_comb begin
        rdata = mem_q[rd_ptr_q];
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        count = count_q;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: drives imem, buffers words with PCs, hands them to decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit
    import riscky_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    fetch_entry_t     wentry, head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             deq, enq;

    // Handshake, enqueue decision and next fetch address; redirect overrides all.
    always_comb begin
        instr_valid  = !fifo_empty && !redirect_valid;
        deq          = instr_valid && instr_ready;
        enq          = !redirect_valid && ((fifo_count < CNT_W'(DEPTH)) || deq);
        wentry.pc    = fetch_pc_q;
        wentry.instr = imem_rdata;
        fetch_pc_d   = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (enq) begin
            fetch_pc_d = fetch_pc_q + INSTR_BYTES;
        end
        imem_addr = fetch_pc_q;
        instr     = head.instr;
        instr_pc  = head.pc;
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (enq),
        .pop  (deq),
        .flush(redirect_valid),
        .wdata(wentry),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Wrapping event counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, enq};
        stall_cnt_d = stall_cnt_q + {31'd0, fifo_full && !deq};
        flush_cnt_d = flush_cnt_q + {31'd0, redirect_valid};
        fetch_cnt   = fetch_cnt_q;
        stall_cnt   = stall_cnt_q;
        flush_cnt   = flush_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`else
    logic unused_full;

    // Counters not built; full is only consumed by the stall counter.
    always_comb begin
        fetch_cnt   = '0;
        stall_cnt   = '0;
        flush_cnt   = '0;
        unused_full = fifo_full;
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed self-checking bench for fetch_prefetch_unit.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: three program words, then an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[31:2])
            30'd0:   return 32'h0000_0093;
            30'd1:   return 32'h0010_0113;
            30'd2:   return 32'h0020_0193;
            default: return {a[31:2], 2'b00} ^ 32'h1357_0000;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_prefetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_pc"}, instr_pc, pc);
        check({tag, "_instr"}, instr, mem_word(pc));
    endtask

    // Hold reset through a falling edge, then release before the next rising edge.
    task automatic do_reset(input logic ready);
        rst         = 1'b0;
        instr_ready = ready;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #3;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_fetch_cnt", fetch_cnt, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_flush_cnt", flush_cnt, 32'h0);

        // Streaming from reset with decode always ready.
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_head("s0", 32'h0);
        check("s0_addr", imem_addr, 32'h4);
        tick();
        check_head("s1", 32'h4);
        tick();
        check_head("s2", 32'h8);
        check("s2_addr", imem_addr, 32'hC);
`ifdef FETCH_PERF_CNT_EN
        check("s_fetch_cnt", fetch_cnt, 32'd3);
`else
        check("s_fetch_cnt", fetch_cnt, 32'd0);
`endif

        // Back-pressure: fill, hold, then drain with no gap while refilling.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("bp_addr", imem_addr, 32'h10);
        check_head("bp_head", 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("bp_stall_cnt", stall_cnt, 32'd6);
        check("bp_fetch_cnt", fetch_cnt, 32'd4);
`else
        check("bp_stall_cnt", stall_cnt, 32'd0);
`endif
        instr_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_head($sformatf("dr%0d", i), 32'(i * 4));
            check($sformatf("dr%0d_addr", i), imem_addr, 32'(16 + i * 4));
        end
`ifdef FETCH_PERF_CNT_EN
        check("dr_stall_cnt", stall_cnt, 32'd6);
`endif

        // Redirect with three entries buffered.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("rd_pre_addr", imem_addr, 32'hC);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        #1;
        check("rd_valid_forced", {31'd0, instr_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rd_addr", imem_addr, 32'h40);
        check("rd_empty", {31'd0, instr_valid}, 32'd0);
        tick();
        check_head("rd0", 32'h40);
        tick();
        check_head("rd1", 32'h44);
`ifdef FETCH_PERF_CNT_EN
        check("rd_flush_cnt", flush_cnt, 32'd1);
`else
        check("rd_flush_cnt", flush_cnt, 32'd0);
`endif

        // Redirect to the top of the address space; fetch wraps to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_head("wr0", 32'hFFFF_FFFC);
        tick();
        check_head("wr1", 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("wr_flush_cnt", flush_cnt, 32'd2);
`endif

        // Asynchronous reset pulse mid-stream.
        tick();
        check_head("ar_pre", 32'h4);
        rst = 1'b0;
        #1;
        check("ar_valid", {31'd0, instr_valid}, 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_pc", instr_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_head("ar0", 32'h0);
        tick();
        check_head("ar1", 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
